// File: rtl/multichannel_gray_synchronizer.sv
// Multi-channel gray-code CDC synchronizer with per-channel stability
// filter, commit strobe, gray-to-binary view and sticky violation flag.
module multichannel_gray_synchronizer #(
  parameter int CHANNEL_COUNT = 2,
  parameter int BUS_WIDTH     = 4,
  parameter int STAGE_COUNT   = 2,
  parameter int STABLE_CYCLES = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CHANNEL_COUNT*BUS_WIDTH-1:0] asynchronous_data,
  input  logic                               error_clear,
  output logic [CHANNEL_COUNT*BUS_WIDTH-1:0] synchronous_data,
  output logic [CHANNEL_COUNT*BUS_WIDTH-1:0] binary_data,
  output logic [CHANNEL_COUNT-1:0]           data_changed,
  output logic [CHANNEL_COUNT-1:0]           gray_error
);

  localparam int CW =
    (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
    logic [BUS_WIDTH-1:0] stg [STAGE_COUNT];
    logic [BUS_WIDTH-1:0] s;
    logic [BUS_WIDTH-1:0] cand;
    logic [BUS_WIDTH-1:0] sd;
    logic [BUS_WIDTH-1:0] diff;
    logic [BUS_WIDTH-1:0] bin;
    logic [CW-1:0]        cnt;
    logic                 commit;
    logic                 multi;
    logic                 chg;
    logic                 err;

    assign s      = stg[STAGE_COUNT-1];
    assign diff   = cand ^ sd;
    assign commit = (s == cand) && (cnt == CMAX) && (diff != '0);
    // more than one bit set iff clearing the lowest set bit leaves any
    assign multi  = (diff & (diff - 1'b1)) != '0;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < STAGE_COUNT; i++) stg[i] <= '0;
        cand <= '0;
        cnt  <= '0;
        sd   <= '0;
        chg  <= 1'b0;
        err  <= 1'b0;
      end else begin
        stg[0] <= asynchronous_data[c*BUS_WIDTH +: BUS_WIDTH];
        for (int i = 1; i < STAGE_COUNT; i++) stg[i] <= stg[i-1];
        if (s != cand) begin
          cand <= s;
          cnt  <= '0;
        end else if (cnt < CMAX) begin
          cnt <= cnt + 1'b1;
        end
        chg <= commit;
        if (commit) sd <= cand;
        if (commit && multi) err <= 1'b1;
        else if (error_clear) err <= 1'b0;
      end
    end

    always_comb begin
      bin = '0;
      for (int i = 0; i < BUS_WIDTH; i++) bin[i] = ^(sd >> i);
    end

    assign synchronous_data[c*BUS_WIDTH +: BUS_WIDTH] = sd;
    assign binary_data[c*BUS_WIDTH +: BUS_WIDTH]      = bin;
    assign data_changed[c]                            = chg;
    assign gray_error[c]                              = err;
  end

endmodule

// File: tb/tb_multichannel_gray_synchronizer.sv
// Directed self-checking bench for multichannel_gray_synchronizer
// (default parameters: 2 channels, 4 bits, 2 stages, 1 stable cycle).
module tb_multichannel_gray_synchronizer;

  logic       clk = 1'b0;
  logic       reset;
  logic       error_clear;
  logic [3:0] a0;
  logic [3:0] a1;
  logic [7:0] din;
  logic [7:0] sync_q;
  logic [7:0] bin_q;
  logic [1:0] chg_q;
  logic [1:0] err_q;

  int checks   = 0;
  int failures = 0;
  int p0       = 0;
  int p1       = 0;

  assign din = {a1, a0};

  multichannel_gray_synchronizer dut (
    .clk               (clk),
    .reset             (reset),
    .asynchronous_data (din),
    .error_clear       (error_clear),
    .synchronous_data  (sync_q),
    .binary_data       (bin_q),
    .data_changed      (chg_q),
    .gray_error        (err_q)
  );

  always #6 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (chg_q[0]) p0++;
    if (chg_q[1]) p1++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] prev;
    int         q1;

    reset       = 1'b1;
    error_clear = 1'b0;
    a0          = 4'h0;
    a1          = 4'h0;
    ticks(3);
    check("rst_sync", sync_q, 8'h00);
    check("rst_bin", bin_q, 8'h00);
    check("rst_chg", chg_q, 2'b00);
    check("rst_err", err_q, 2'b00);
    reset = 1'b0;
    p0 = 0;
    p1 = 0;

    // gray count 1..15 on ch0
    prev = 4'h0;
    for (int i = 1; i < 16; i++) begin
      g  = 4'(i ^ (i >> 1));
      a0 = g;
      ticks(4);
      check("cnt_hold", {28'h0, sync_q[3:0]}, {28'h0, prev});
      tick();
      check("cnt_sync", {28'h0, sync_q[3:0]}, {28'h0, g});
      check("cnt_bin", {28'h0, bin_q[3:0]}, 32'(i));
      check("cnt_chg", {30'h0, chg_q}, 32'h1);
      tick();
      check("cnt_chg_off", {30'h0, chg_q}, 32'h0);
      prev = g;
    end
    check("cnt_pulses", p0, 15);
    check("cnt_err", {30'h0, err_q}, 32'h0);

    // one-sample glitch on ch1 is filtered
    q1 = p1;
    a1 = 4'h1;
    tick();
    a1 = 4'h0;
    ticks(8);
    check("glitch_pulses", p1 - q1, 0);
    check("glitch_sync", {28'h0, sync_q[7:4]}, 32'h0);
    a1 = 4'h1;
    ticks(4);
    check("hold_pre", {28'h0, sync_q[7:4]}, 32'h0);
    tick();
    check("hold_sync", {28'h0, sync_q[7:4]}, 32'h1);
    check("hold_chg", {30'h0, chg_q}, 32'h2);
    check("hold_err", {30'h0, err_q}, 32'h0);

    // gray violation 0000 -> 0011 on ch0
    a0 = 4'h0;
    ticks(6);
    check("viol_base", {28'h0, sync_q[3:0]}, 32'h0);
    a0 = 4'h3;
    ticks(5);
    check("viol_sync", {28'h0, sync_q[3:0]}, 32'h3);
    check("viol_bin", {28'h0, bin_q[3:0]}, 32'h2);
    check("viol_err", {30'h0, err_q}, 32'h1);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    check("viol_clr", {30'h0, err_q}, 32'h0);

    // clear collides with violating commit 0011 -> 0100
    a0 = 4'h4;
    ticks(4);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    check("coll_sync", {28'h0, sync_q[3:0]}, 32'h4);
    check("coll_err", {30'h0, err_q}, 32'h1);

    // reset while 0111 sits in the first stage
    a0 = 4'h7;
    tick();
    reset = 1'b1;
    tick();
    check("mrst_sync", sync_q, 8'h00);
    check("mrst_bin", bin_q, 8'h00);
    check("mrst_chg", chg_q, 2'b00);
    check("mrst_err", err_q, 2'b00);
    reset = 1'b0;
    ticks(4);
    check("mrst_pre", sync_q, 8'h00);
    tick();
    check("mrst_sync2", sync_q, 8'h17);
    check("mrst_bin2", bin_q, 8'h15);
    check("mrst_chg2", chg_q, 2'b11);
    check("mrst_err2", err_q, 2'b01);

    // simultaneous commits on both channels
    a0 = 4'h0;
    a1 = 4'h0;
    ticks(6);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    check("ind_base", {sync_q, 22'h0, err_q}, {8'h00, 24'h0});
    a0 = 4'h1;
    a1 = 4'h3;
    ticks(4);
    check("ind_pre", sync_q, 8'h00);
    tick();
    check("ind_sync", sync_q, 8'h31);
    check("ind_bin", bin_q, 8'h21);
    check("ind_chg", chg_q, 2'b11);
    check("ind_err", err_q, 2'b10);
    tick();
    check("ind_chg_off", chg_q, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
